// File: rtl/ram3840_pkg.sv
// Shared definitions for the RAM3840 two-requester arbiter.
// Holds the bus widths, the arbiter state encoding, the requester IDs
// and small address helpers used by the arbiter and its response channels.
package ram3840_pkg;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 16;
  localparam int BANK_W    = 4;
  localparam int MEM_WORDS = 3840;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_e;

  typedef logic req_id_t;
  localparam req_id_t REQ_A = 1'b0;
  localparam req_id_t REQ_B = 1'b1;

  // The address is widened by one bit so a limit of 4096 still compares correctly.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W:0]   limit);
    return ({1'b0, addr} < limit);
  endfunction

  function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: BANK_W];
  endfunction

endpackage

// File: rtl/arb_resp_channel.sv
// Per-requester read-return channel.
// Captures the RAM read data (or zero for an out-of-range access) and the
// error flag on the grant edge, and pulses rvalid for the following cycle.
// Ports:
//   clk, reset    - system clock, synchronous active-high reset
//   gnt_i         - this requester was granted in the current cycle
//   oor_i         - the granted address is out of range
//   mem_out_i     - combinational RAM read data
//   rvalid_o      - one-cycle pulse after each grant
//   rdata_o/err_o - captured read data / error, held until the next grant
module arb_resp_channel
  import ram3840_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              gnt_i,
  input  logic              oor_i,
  input  logic [DATA_W-1:0] mem_out_i,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o
);

  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= gnt_i;
      if (gnt_i) begin
        rdata_q <= oor_i ? '0 : mem_out_i;
        err_q   <= oor_i;
      end
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule

// File: rtl/ram3840_arbiter.sv
// Two-requester arbiter for the single-port RAM3840.
// Requester A is the CPU data port, requester B the loader/DMA port.
// Round-robin in IDLE; a requester asking for lock keeps ownership for up to
// MAX_BURST consecutive grants while the other side waits. Out-of-range
// accesses (addr >= LIMIT) never write and return err with zero data.
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   a_* / b_*             - request/grant handshake and read return per requester
//   mem_address/in/load   - drive the RAM3840 directly
//   mem_out               - RAM3840 combinational read data
//
// state | meaning
// IDLE  | no owner, round-robin between requesters
// OWN_A | A holds a lock; only A is granted until lock drops or burst expires
// OWN_B | B holds a lock; only B is granted until lock drops or burst expires
module ram3840_arbiter
  import ram3840_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned LIMIT     = MEM_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out
);

  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_BURST);
  localparam logic [ADDR_W:0]  LIMIT_C = (ADDR_W+1)'(LIMIT);

  arb_state_e       state_q, state_d;
  req_id_t          rr_last_q, rr_last_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic             gnt_a, gnt_b;
  logic             a_gnt_w, b_gnt_w;
  logic             sel_lock, other_req;
  logic [CNT_W-1:0] cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_last_q   <= REQ_B;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    burst_cnt_d = burst_cnt_q;
    gnt_a       = 1'b0;
    gnt_b       = 1'b0;
    sel_lock    = 1'b0;
    other_req   = 1'b0;
    cnt_nxt     = '0;

    case (state_q)
      IDLE: begin
        if (a_req && b_req) begin
          gnt_a = (rr_last_q == REQ_B);
          gnt_b = (rr_last_q == REQ_A);
        end else begin
          gnt_a = a_req;
          gnt_b = b_req;
        end
      end
      OWN_A: begin
        gnt_a = a_req;
        // Owner idle with an exhausted burst: release so B wins next cycle.
        if (!a_req && b_req && (burst_cnt_q >= MAX_C)) begin
          state_d     = IDLE;
          burst_cnt_d = '0;
        end
      end
      OWN_B: begin
        gnt_b = b_req;
        if (!b_req && a_req && (burst_cnt_q >= MAX_C)) begin
          state_d     = IDLE;
          burst_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (gnt_a || gnt_b) begin
      rr_last_d = gnt_b ? REQ_B : REQ_A;
      sel_lock  = gnt_b ? b_lock : a_lock;
      other_req = gnt_b ? a_req : b_req;
      if (!sel_lock) begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end else begin
        if (state_q == IDLE)         cnt_nxt = CNT_W'(1);
        else if (burst_cnt_q >= MAX_C) cnt_nxt = MAX_C;
        else                         cnt_nxt = burst_cnt_q + CNT_W'(1);
        // rr_last already points at the owner, so IDLE hands the next grant over.
        if ((cnt_nxt >= MAX_C) && other_req) begin
          state_d     = IDLE;
          burst_cnt_d = '0;
        end else begin
          state_d     = gnt_b ? OWN_B : OWN_A;
          burst_cnt_d = cnt_nxt;
        end
      end
    end
  end

  // Grants are masked during reset so no write can slip through that cycle.
  assign a_gnt_w = gnt_a && !reset;
  assign b_gnt_w = gnt_b && !reset;
  assign a_gnt   = a_gnt_w;
  assign b_gnt   = b_gnt_w;

  always_comb begin
    mem_address = '0;
    mem_in      = '0;
    mem_load    = 1'b0;
    if (a_gnt_w) begin
      mem_address = a_addr;
      mem_in      = a_wdata;
      mem_load    = a_we && in_range(a_addr, LIMIT_C);
    end else if (b_gnt_w) begin
      mem_address = b_addr;
      mem_in      = b_wdata;
      mem_load    = b_we && in_range(b_addr, LIMIT_C);
    end
  end

  arb_resp_channel u_resp_a (
    .clk       (clk),
    .reset     (reset),
    .gnt_i     (a_gnt_w),
    .oor_i     (!in_range(a_addr, LIMIT_C)),
    .mem_out_i (mem_out),
    .rvalid_o  (a_rvalid),
    .rdata_o   (a_rdata),
    .err_o     (a_err)
  );

  arb_resp_channel u_resp_b (
    .clk       (clk),
    .reset     (reset),
    .gnt_i     (b_gnt_w),
    .oor_i     (!in_range(b_addr, LIMIT_C)),
    .mem_out_i (mem_out),
    .rvalid_o  (b_rvalid),
    .rdata_o   (b_rdata),
    .err_o     (b_err)
  );

endmodule

// File: tb/tb_ram3840_arbiter.sv
module tb_ram3840_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, a_lock;
  logic [11:0] a_addr;
  logic [15:0] a_wdata;
  logic        a_gnt, a_rvalid, a_err;
  logic [15:0] a_rdata;
  logic        b_req, b_we, b_lock;
  logic [11:0] b_addr;
  logic [15:0] b_wdata;
  logic        b_gnt, b_rvalid, b_err;
  logic [15:0] b_rdata;
  logic [11:0] mem_address;
  logic [15:0] mem_in;
  logic        mem_load;
  logic [15:0] mem_out;

  logic [15:0] ram [0:4095];
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [15:0] pl_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // RAM3840 stand-in: combinational read, write on the rising edge.
  assign mem_out = ram[mem_address];
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_load) ram[mem_address] <= mem_in;
  end

  ram3840_arbiter #(.MAX_BURST(4), .LIMIT(3840)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .mem_address(mem_address), .mem_in(mem_in), .mem_load(mem_load), .mem_out(mem_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic preload(input logic [11:0] ad, input logic [15:0] d);
    pl_en = 1; pl_addr = ad; pl_data = d;
    step();
    pl_en = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    a_req = 1; a_we = 1; a_addr = 12'h005; a_wdata = 16'hAAAA; b_req = 1;
    #1;
    checks++; if (a_gnt !== 1'b0) begin errors++; $display("FAIL rst_a_gnt: got %b want 0", a_gnt); end
    checks++; if (b_gnt !== 1'b0) begin errors++; $display("FAIL rst_b_gnt: got %b want 0", b_gnt); end
    checks++; if (mem_load !== 1'b0) begin errors++; $display("FAIL rst_mem_load: got %b want 0", mem_load); end
    checks++; if (mem_address !== 12'h000) begin errors++; $display("FAIL rst_mem_address: got %h want 000", mem_address); end
    step();
    checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got a=%b b=%b want 0 0", a_rvalid, b_rvalid); end
    checks++; if (a_rdata !== 16'h0 || a_err !== 1'b0) begin errors++; $display("FAIL rst_a_resp: got rdata=%h err=%b want 0000 0", a_rdata, a_err); end
    checks++; if (ram[5] !== 16'h0000) begin errors++; $display("FAIL rst_no_write: got %h want 0000", ram[5]); end
    idle_inputs();
    reset = 0;
  endtask

  task automatic test_write_read();
    a_req = 1; a_we = 1; a_addr = 12'h005; a_wdata = 16'h1234;
    #1;
    checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL wr_a_gnt: got %b want 1", a_gnt); end
    checks++; if (mem_load !== 1'b1) begin errors++; $display("FAIL wr_mem_load: got %b want 1", mem_load); end
    checks++; if (mem_address !== 12'h005 || mem_in !== 16'h1234) begin errors++; $display("FAIL wr_mem_bus: got %h/%h want 005/1234", mem_address, mem_in); end
    step();
    checks++; if (a_rvalid !== 1'b1 || a_rdata !== 16'h0000) begin errors++; $display("FAIL wr_resp: got rvalid=%b rdata=%h want 1 0000", a_rvalid, a_rdata); end
    a_we = 0;
    #1;
    checks++; if (a_gnt !== 1'b1 || mem_load !== 1'b0) begin errors++; $display("FAIL rd_gnt_load: got gnt=%b load=%b want 1 0", a_gnt, mem_load); end
    step();
    checks++; if (a_rvalid !== 1'b1 || a_rdata !== 16'h1234 || a_err !== 1'b0) begin errors++; $display("FAIL rd_resp: got %b %h %b want 1 1234 0", a_rvalid, a_rdata, a_err); end
    idle_inputs();
    step();
    checks++; if (a_rvalid !== 1'b0 || a_rdata !== 16'h1234) begin errors++; $display("FAIL rd_hold: got rvalid=%b rdata=%h want 0 1234", a_rvalid, a_rdata); end
  endtask

  task automatic test_round_robin();
    logic exp_a;
    do_reset();
    a_req = 1; a_addr = 12'h010; b_req = 1; b_addr = 12'h020;
    for (int i = 0; i < 6; i++) begin
      exp_a = (i % 2 == 0);
      #1;
      checks++; if (a_gnt !== exp_a || b_gnt !== !exp_a) begin errors++; $display("FAIL rr_gnt[%0d]: got a=%b b=%b want a=%b b=%b", i, a_gnt, b_gnt, exp_a, !exp_a); end
      step();
      checks++; if (a_rvalid !== exp_a || b_rvalid !== !exp_a) begin errors++; $display("FAIL rr_rvalid[%0d]: got a=%b b=%b want a=%b b=%b", i, a_rvalid, b_rvalid, exp_a, !exp_a); end
      if (exp_a) begin
        checks++; if (a_rdata !== 16'h1111) begin errors++; $display("FAIL rr_a_rdata[%0d]: got %h want 1111", i, a_rdata); end
      end else begin
        checks++; if (b_rdata !== 16'h2222) begin errors++; $display("FAIL rr_b_rdata[%0d]: got %h want 2222", i, b_rdata); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_lock_burst();
    bit exp_a [8] = '{1, 1, 1, 1, 0, 1, 0, 1};
    do_reset();
    a_req = 1; a_addr = 12'h010; b_req = 1; b_addr = 12'h020;
    for (int i = 0; i < 8; i++) begin
      a_lock = (i < 4);
      #1;
      checks++; if (a_gnt !== exp_a[i] || b_gnt !== !exp_a[i]) begin errors++; $display("FAIL lock_gnt[%0d]: got a=%b b=%b want a=%b b=%b", i, a_gnt, b_gnt, exp_a[i], !exp_a[i]); end
      step();
      checks++; if (b_rvalid !== !exp_a[i]) begin errors++; $display("FAIL lock_b_rvalid[%0d]: got %b want %b", i, b_rvalid, !exp_a[i]); end
    end
    idle_inputs();
  endtask

  task automatic test_out_of_range();
    do_reset();
    b_req = 1; b_we = 1; b_addr = 12'hF00; b_wdata = 16'hBEEF;
    #1;
    checks++; if (b_gnt !== 1'b1 || mem_load !== 1'b0) begin errors++; $display("FAIL oor_gnt_load: got gnt=%b load=%b want 1 0", b_gnt, mem_load); end
    step();
    checks++; if (b_rvalid !== 1'b1 || b_err !== 1'b1 || b_rdata !== 16'h0000) begin errors++; $display("FAIL oor_resp: got %b %b %h want 1 1 0000", b_rvalid, b_err, b_rdata); end
    checks++; if (ram[12'hF00] !== 16'h7777) begin errors++; $display("FAIL oor_no_write: got %h want 7777", ram[12'hF00]); end
    b_we = 0; b_addr = 12'h000;
    step();
    checks++; if (b_rvalid !== 1'b1 || b_err !== 1'b0 || b_rdata !== 16'h0C0C) begin errors++; $display("FAIL oor_read0: got %b %b %h want 1 0 0c0c", b_rvalid, b_err, b_rdata); end
    b_req = 0;
    a_req = 1; a_addr = 12'hEFF;
    step();
    checks++; if (a_err !== 1'b0 || a_rdata !== 16'h3839) begin errors++; $display("FAIL last_legal_rd: got err=%b rdata=%h want 0 3839", a_err, a_rdata); end
    checks++; if (b_rvalid !== 1'b0 || b_rdata !== 16'h0C0C) begin errors++; $display("FAIL b_hold: got %b %h want 0 0c0c", b_rvalid, b_rdata); end
    a_we = 1; a_wdata = 16'h4444;
    #1;
    checks++; if (mem_load !== 1'b1) begin errors++; $display("FAIL last_legal_wr: got load=%b want 1", mem_load); end
    step();
    a_we = 0; a_addr = 12'hFFF;
    step();
    checks++; if (a_err !== 1'b1 || a_rdata !== 16'h0000) begin errors++; $display("FAIL top_addr: got err=%b rdata=%h want 1 0000", a_err, a_rdata); end
    checks++; if (ram[12'hEFF] !== 16'h4444) begin errors++; $display("FAIL last_legal_mem: got %h want 4444", ram[12'hEFF]); end
    idle_inputs();
  endtask

  task automatic test_own_hold();
    bit a_pat [7] = '{1, 1, 0, 0, 1, 1, 1};
    bit exp_a [7] = '{1, 1, 0, 0, 1, 1, 0};
    bit exp_b [7] = '{0, 0, 0, 0, 0, 0, 1};
    do_reset();
    a_lock = 1; a_addr = 12'h010; b_req = 1; b_addr = 12'h020;
    for (int i = 0; i < 7; i++) begin
      a_req = a_pat[i];
      #1;
      checks++; if (a_gnt !== exp_a[i] || b_gnt !== exp_b[i]) begin errors++; $display("FAIL hold_gnt[%0d]: got a=%b b=%b want a=%b b=%b", i, a_gnt, b_gnt, exp_a[i], exp_b[i]); end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_req = 1; a_lock = 1; a_addr = 12'h010;
    #1;
    checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL mid_first_gnt: got %b want 1", a_gnt); end
    step();
    reset = 1; a_we = 1; a_wdata = 16'hDEAD;
    #1;
    checks++; if (a_gnt !== 1'b0 || mem_load !== 1'b0) begin errors++; $display("FAIL mid_rst_gnt: got gnt=%b load=%b want 0 0", a_gnt, mem_load); end
    step();
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid: got %b want 0", a_rvalid); end
    checks++; if (ram[12'h010] !== 16'h1111) begin errors++; $display("FAIL mid_no_write: got %h want 1111", ram[12'h010]); end
    reset = 0;
    idle_inputs();
    b_req = 1; b_addr = 12'h020;
    #1;
    checks++; if (b_gnt !== 1'b1) begin errors++; $display("FAIL mid_b_gnt: got %b want 1", b_gnt); end
    step();
    checks++; if (b_rvalid !== 1'b1 || b_rdata !== 16'h2222) begin errors++; $display("FAIL mid_b_resp: got %b %h want 1 2222", b_rvalid, b_rdata); end
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    pl_en = 0; pl_addr = '0; pl_data = '0;
    idle_inputs();
    preload(12'h005, 16'h0000);
    preload(12'h010, 16'h1111);
    preload(12'h020, 16'h2222);
    preload(12'h000, 16'h0C0C);
    preload(12'hF00, 16'h7777);
    preload(12'hEFF, 16'h3839);
    preload(12'hFFF, 16'h9999);
    test_reset();
    test_write_read();
    test_round_robin();
    test_lock_burst();
    test_out_of_range();
    test_own_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
